// File: rtl/max_seq_ctrl.sv
// max_seq_ctrl: frame maximum over COUNT samples through one shared comparator.
// Define MAX_SEQ_INDEX_EN to add the winning-index register and out_idx port.
module max_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
`ifdef MAX_SEQ_INDEX_EN
    output logic [IDXW-1:0]  out_idx,
`endif
    output logic             busy
);

    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_ACC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
`ifdef MAX_SEQ_INDEX_EN
    logic [IDXW-1:0]  r_idx;
`endif

    logic             w_accept;
    logic             w_gt;
    logic [WIDTH-1:0] w_max;
    logic             w_last;

    // The single shared comparator; strict '>' keeps the earlier sample on ties.
    assign w_gt     = in_data > r_acc;
    assign w_max    = w_gt ? in_data : r_acc;
    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_cnt == CW'(COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MAX_SEQ_INDEX_EN
            r_idx       <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FIRST;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FIRST: begin
                    if (w_accept) begin
                        r_acc <= in_data;
                        r_cnt <= CW'(1);
`ifdef MAX_SEQ_INDEX_EN
                        r_idx <= '0;
`endif
                        if (COUNT == 1) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_max;
                        r_cnt <= r_cnt + CW'(1);
`ifdef MAX_SEQ_INDEX_EN
                        if (w_gt) r_idx <= IDXW'(r_cnt);
`endif
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_max   = r_acc;
    assign busy      = r_busy;
`ifdef MAX_SEQ_INDEX_EN
    assign out_idx   = r_idx;
`endif

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Self-checking bench for max_seq_ctrl: vector table, corner sequences,
// randomized frames against a reference model, plus a COUNT=1 instance.
module tb_max_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, busy;
    logic [3:0] out_max;
    logic       start1, in_valid1, out_ready1;
    logic [3:0] in_data1;
    logic       in_ready1, out_valid1, busy1;
    logic [3:0] out_max1;
`ifdef MAX_SEQ_INDEX_EN
    logic [1:0] out_idx;
    logic [0:0] out_idx1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    max_seq_ctrl #(.WIDTH(4), .COUNT(4), .IDXW(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
`ifdef MAX_SEQ_INDEX_EN
        .out_idx(out_idx),
`endif
        .busy(busy)
    );

    max_seq_ctrl #(.WIDTH(4), .COUNT(1), .IDXW(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_max(out_max1),
`ifdef MAX_SEQ_INDEX_EN
        .out_idx(out_idx1),
`endif
        .busy(busy1)
    );

    typedef struct {
        logic [15:0] s;
        logic [3:0]  m;
        logic [1:0]  ix;
        bit          gap;
        int          stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the frame maximum, then the first position holding it.
    function automatic void model(input logic [15:0] s,
                                  output logic [3:0] m,
                                  output logic [1:0] ix);
        int best;
        int pos;
        best = 0;
        for (int i = 0; i < 4; i++)
            if (int'(s[i*4 +: 4]) > best) best = int'(s[i*4 +: 4]);
        pos = -1;
        for (int i = 3; i >= 0; i--)
            if (int'(s[i*4 +: 4]) == best) pos = i;
        m  = 4'(best);
        ix = 2'(pos);
    endfunction

    // Inputs change at posedge+1; outputs are sampled there too.
    task automatic run_frame(input string nm, input logic [15:0] s,
                             input logic [3:0] em, input logic [1:0] eix,
                             input bit gap, input int stall);
        int acc_n;
        int cyc;
        bit take;
        logic [3:0] held;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy_start"}, busy, 1);
        chk({nm, "_ready_first"}, in_ready, 1);
        acc_n = 0;
        cyc = 0;
        while (acc_n < 4 && cyc < 40) begin
            in_valid = gap ? (cyc % 2 == 0) : 1'b1;
            in_data  = in_valid ? s[acc_n*4 +: 4] : 4'hF;
            start    = gap && (cyc == 1);
            take     = in_valid & in_ready;
            @(posedge clk); #1;
            if (take) acc_n++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (acc_n < 4) chk({nm, "_accept_timeout"}, acc_n, 4);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_ready_done"}, in_ready, 0);
        chk({nm, "_busy_done"}, busy, 1);
        chk({nm, "_max"}, out_max, em);
`ifdef MAX_SEQ_INDEX_EN
        chk({nm, "_idx"}, out_idx, eix);
`else
        if (eix !== eix) chk({nm, "_idx_x"}, 0, 1);
`endif
        held = out_max;
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({nm, "_stall_valid"}, out_valid, 1);
            chk({nm, "_stall_max"}, out_max, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_valid_clear"}, out_valid, 0);
        chk({nm, "_busy_clear"}, busy, 0);
    endtask

    vec_t vt[8];
    logic [15:0] rs;
    logic [3:0]  rm;
    logic [1:0]  rix;

    initial begin
        vt[0] = '{16'h09AB, 4'hB, 2'd0, 1'b0, 0};
        vt[1] = '{16'h2AC5, 4'hC, 2'd1, 1'b0, 0};
        vt[2] = '{16'hF421, 4'hF, 2'd3, 1'b0, 0};
        vt[3] = '{16'h7377, 4'h7, 2'd0, 1'b0, 0};
        vt[4] = '{16'h0000, 4'h0, 2'd0, 1'b0, 0};
        vt[5] = '{16'h09AB, 4'hB, 2'd0, 1'b1, 0};
        vt[6] = '{16'h09AB, 4'hB, 2'd0, 1'b0, 5};
        vt[7] = '{16'h8E3E, 4'hE, 2'd0, 1'b1, 2};

        rst_n = 1'b0;
        start = 0; in_valid = 0; out_ready = 0; in_data = 0;
        start1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = 0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_busy", busy, 0);
`ifdef MAX_SEQ_INDEX_EN
        chk("rst_out_idx", out_idx, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vt[i].s, vt[i].m,
                      vt[i].ix, vt[i].gap, vt[i].stall);

        // Stray in_valid in IDLE must not be taken.
        in_valid = 1'b1;
        in_data  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        // Abort after two accepts.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h3;
        @(posedge clk); #1;
        in_data = 4'h8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", in_ready, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_max", out_max, 0);
        chk("abort_busy", busy, 0);
`ifdef MAX_SEQ_INDEX_EN
        chk("abort_idx", out_idx, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_abort", 16'h4183, 4'h8, 2'd1, 1'b0, 0);

        for (int r = 0; r < 25; r++) begin
            rs = 16'($urandom);
            if (r % 5 == 0) rs[7:4] = rs[3:0];
            model(rs, rm, rix);
            run_frame($sformatf("rnd%0d", r), rs, rm, rix,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // COUNT=1 instance.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("one_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1 = 4'hA;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("one_valid", out_valid1, 1);
        chk("one_max", out_max1, 4'hA);
`ifdef MAX_SEQ_INDEX_EN
        chk("one_idx", out_idx1, 0);
`endif
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("one_clear", out_valid1, 0);
        chk("one_busy", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
